// File: rtl/filter_ctrl_pkg.sv
// Shared types and widths for the filter frame controller and the filter modules
// that reuse its position counter.
package filter_ctrl_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_BLUR   = 2'd1,
    MODE_EDGE   = 2'd2,
    MODE_THRESH = 2'd3
  } mode_t;

  localparam int FRAME_CNT_W = 16;
  localparam int DROP_CNT_W  = 16;

  // Width of a coordinate for a dimension of n; a 1-pixel dimension still gets one bit.
  function automatic int pos_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_position_counter.sv
// Raster x/y tracker. restart rewinds to (0,0); restart together with advance
// lands on the position that follows (0,0).
module frame_position_counter
  import filter_ctrl_pkg::*;
#(
  parameter int W = 640,
  parameter int H = 480
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  advance,
  input  logic                  restart,
  output logic [pos_w(W)-1:0]   x,
  output logic [pos_w(H)-1:0]   y,
  output logic                  last
);
  localparam int XW = pos_w(W);
  localparam int YW = pos_w(H);

  logic [XW-1:0] base_x, x_nx;
  logic [YW-1:0] base_y, y_nx;

  always_comb begin
    base_x = restart ? '0 : x;
    base_y = restart ? '0 : y;
    x_nx   = base_x;
    y_nx   = base_y;
    if (advance) begin
      if (base_x == XW'(W - 1)) begin
        x_nx = '0;
        y_nx = (base_y == YW'(H - 1)) ? '0 : base_y + 1'b1;
      end else begin
        x_nx = base_x + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (advance || restart) begin
      x <= x_nx;
      y <= y_nx;
    end
  end

  assign last = (x == XW'(W - 1)) && (y == YW'(H - 1));

endmodule

// File: rtl/filter_frame_controller.sv
// Frame sequencer in front of the filter bank: sof lock, x/y tracking, border
// flagging, per-frame mode latch and frame/resync/drop reporting.
module filter_frame_controller
  import filter_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                          clk,
  input  logic                          reset,
  input  mode_t                         mode_req,
  input  logic [DATA_WIDTH-1:0]         src_data,
  input  logic                          src_valid,
  input  logic                          src_sof,
  output logic                          src_ready,
  output logic [DATA_WIDTH-1:0]         flt_data,
  output logic                          flt_valid,
  input  logic                          flt_ready,
  output logic [pos_w(IMG_WIDTH)-1:0]   flt_x,
  output logic [pos_w(IMG_HEIGHT)-1:0]  flt_y,
  output logic                          flt_border,
  output mode_t                         active_mode,
  output logic                          frame_done,
  output logic                          sync_err,
  output logic [FRAME_CNT_W-1:0]        frame_count,
  output logic [DROP_CNT_W-1:0]         drop_count
);
  localparam int XW = pos_w(IMG_WIDTH);
  localparam int YW = pos_w(IMG_HEIGHT);

  state_t        state, state_nx;
  logic [XW-1:0] cnt_x;
  logic [YW-1:0] cnt_y;
  logic          cnt_last;
  logic          flt_xfer, sof_xfer, eof_p0, resync_p0, drop_p0;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_comb begin
    src_ready = 1'b1;
    flt_valid = 1'b0;
    state_nx  = state;
    case (state)
      IDLE: begin
        src_ready = src_sof ? flt_ready : 1'b1;
        flt_valid = src_valid & src_sof;
      end
      ACTIVE: begin
        src_ready = flt_ready;
        flt_valid = src_valid;
      end
      default: ;
    endcase
    flt_xfer  = flt_valid & flt_ready;
    sof_xfer  = flt_xfer & src_sof;
    // sof outranks end-of-frame, so a sof on the last pixel is a resync
    eof_p0    = flt_xfer & ~src_sof & (state == ACTIVE) & cnt_last;
    resync_p0 = sof_xfer & (state == ACTIVE) & ((cnt_x != '0) | (cnt_y != '0));
    drop_p0   = (state == IDLE) & src_valid & ~src_sof;
    if (sof_xfer)    state_nx = ACTIVE;
    else if (eof_p0) state_nx = IDLE;
  end

  frame_position_counter #(
    .W (IMG_WIDTH),
    .H (IMG_HEIGHT)
  ) u_pos (
    .clk     (clk),
    .reset   (reset),
    .advance (flt_xfer),
    .restart (sof_xfer),
    .x       (cnt_x),
    .y       (cnt_y),
    .last    (cnt_last)
  );

  assign flt_data   = src_data;
  assign flt_x      = src_sof ? '0 : cnt_x;
  assign flt_y      = src_sof ? '0 : cnt_y;
  assign flt_border = (flt_x == '0) || (flt_x == XW'(IMG_WIDTH - 1)) ||
                      (flt_y == '0) || (flt_y == YW'(IMG_HEIGHT - 1));

  // Stage p0 -> p1: event pulses and counters register one cycle after the transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      active_mode <= MODE_BYPASS;
      frame_done  <= 1'b0;
      sync_err    <= 1'b0;
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      state      <= state_nx;
      frame_done <= eof_p0;
      sync_err   <= resync_p0;
      if (sof_xfer) active_mode <= mode_req;
      if (eof_p0)   frame_count <= frame_count + 1'b1;
      if (drop_p0)  drop_count  <= sat_inc(drop_count);
    end
  end

endmodule

// File: tb/tb_filter_frame_controller.sv
// Directed and randomized bench for filter_frame_controller (4x3 frames) against
// a raster-index reference model.
module tb_filter_frame_controller;
  import filter_ctrl_pkg::*;

  localparam int W = 4;
  localparam int H = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  mode_t       mode_req = MODE_BYPASS;
  logic [7:0]  src_data = '0;
  logic        src_valid = 1'b0;
  logic        src_sof = 1'b0;
  logic        src_ready;
  logic [7:0]  flt_data;
  logic        flt_valid;
  logic        flt_ready = 1'b1;
  logic [1:0]  flt_x;
  logic [1:0]  flt_y;
  logic        flt_border;
  mode_t       active_mode;
  logic        frame_done;
  logic        sync_err;
  logic [15:0] frame_count;
  logic [15:0] drop_count;

  filter_frame_controller #(
    .DATA_WIDTH (8),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mode_req    (mode_req),
    .src_data    (src_data),
    .src_valid   (src_valid),
    .src_sof     (src_sof),
    .src_ready   (src_ready),
    .flt_data    (flt_data),
    .flt_valid   (flt_valid),
    .flt_ready   (flt_ready),
    .flt_x       (flt_x),
    .flt_y       (flt_y),
    .flt_border  (flt_border),
    .active_mode (active_mode),
    .frame_done  (frame_done),
    .sync_err    (sync_err),
    .frame_count (frame_count),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int dut_xfers = 0;

  // Reference model: synchronised flag plus linear raster index of the next pixel
  bit         m_synced;
  int         m_pos;
  int         m_frames;
  int         m_drops;
  logic [1:0] m_mode;
  bit         tog;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_synced = 0; m_pos = 0; m_frames = 0; m_drops = 0; m_mode = 2'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1; src_valid = 1'b0; src_sof = 1'b0; flt_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    #1;
    chk("rst_src_ready", src_ready, 1);
    chk("rst_flt_valid", flt_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_sync_err", sync_err, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_active_mode", active_mode, 0);
  endtask

  // One clock: drive, check combinational outputs, advance model, check registered outputs
  task automatic cycle(input bit sof, input bit valid, input logic [7:0] data,
                       input bit rdy, input logic [1:0] mode, output bit sx);
    bit e_rdy, e_vld, fx, e_done, e_err;
    int ex, ey;
    src_sof = sof; src_valid = valid; src_data = data; flt_ready = rdy;
    mode_req = mode_t'(mode);
    #1;
    e_rdy = m_synced ? rdy : (sof ? rdy : 1'b1);
    e_vld = m_synced ? valid : (valid & sof);
    chk("src_ready", src_ready, e_rdy);
    chk("flt_valid", flt_valid, e_vld);
    if (e_vld) begin
      ex = sof ? 0 : m_pos % W;
      ey = sof ? 0 : m_pos / W;
      chk("flt_x", flt_x, ex);
      chk("flt_y", flt_y, ey);
      chk("flt_border", flt_border, (ex == 0 || ex == W-1 || ey == 0 || ey == H-1));
      chk("flt_data", flt_data, data);
    end
    if (flt_valid && flt_ready) dut_xfers++;
    fx = e_vld & rdy;
    sx = valid & e_rdy;
    e_done = 0; e_err = 0;
    if (!m_synced && valid && !sof) m_drops = (m_drops == 65535) ? 65535 : m_drops + 1;
    if (fx) begin
      if (sof) begin
        if (m_synced && m_pos != 0) e_err = 1;
        m_synced = 1; m_mode = mode; m_pos = 1 % (W*H);
      end else if (m_pos == W*H-1) begin
        m_synced = 0; m_pos = 0; m_frames = (m_frames + 1) % 65536; e_done = 1;
      end else begin
        m_pos++;
      end
    end
    @(posedge clk); #1;
    chk("frame_done", frame_done, e_done);
    chk("sync_err", sync_err, e_err);
    chk("frame_count", frame_count, m_frames);
    chk("drop_count", drop_count, m_drops);
    chk("active_mode", active_mode, m_mode);
  endtask

  // Offer one pixel and hold it until the source side accepts it
  task automatic send(input bit sof, input logic [1:0] mode, input bit toggle);
    bit sx;
    logic [7:0] d;
    d = 8'($urandom);
    sx = 0;
    for (int t = 0; t < 20 && !sx; t++) begin
      cycle(sof, 1'b1, d, toggle ? tog : 1'b1, mode, sx);
      tog = ~tog;
    end
    if (!sx) chk("xfer_timeout", 0, 1);
  endtask

  initial begin
    bit sx;
    tog = 0;
    model_clear();
    // Scenario 1: clean frame
    do_reset();
    for (int i = 0; i < W*H; i++) send(i == 0, 2'd0, 0);
    chk("s1_frames", frame_count, 1);

    // Scenario 2: unsynchronised pixels dropped, then a frame
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'($urandom), 1'b1, 2'd0, sx);
    chk("s2_drops", drop_count, 5);
    for (int i = 0; i < W*H; i++) send(i == 0, 2'd0, 0);
    chk("s2_frames", frame_count, 1);

    // Scenario 3: flt_ready toggling
    do_reset();
    dut_xfers = 0;
    for (int i = 0; i < W*H; i++) send(i == 0, 2'd0, 1);
    chk("s3_xfers", dut_xfers, W*H);
    chk("s3_frames", frame_count, 1);

    // Scenario 4: resync on pixel 7
    do_reset();
    for (int i = 0; i < 6; i++) send(i == 0, 2'd0, 0);
    send(1'b1, 2'd0, 0);
    for (int i = 0; i < W*H-1; i++) send(1'b0, 2'd0, 0);
    chk("s4_frames", frame_count, 1);

    // Scenario 5: mode latched only at sof
    do_reset();
    for (int i = 0; i < W*H; i++) send(i == 0, (i == 0) ? 2'd1 : 2'd2, 0);
    chk("s5_mode_blur", active_mode, MODE_BLUR);
    send(1'b1, 2'd2, 0);
    chk("s5_mode_edge", active_mode, MODE_EDGE);

    // Scenario 6: reset mid-frame
    do_reset();
    for (int i = 0; i < 5; i++) send(i == 0, 2'd3, 0);
    do_reset();
    for (int i = 0; i < W*H; i++) send(i == 0, 2'd0, 0);
    chk("s6_frames", frame_count, 1);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, 8'($urandom),
            $urandom_range(0, 3) != 0, 2'($urandom), sx);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
